// File: rtl/ss_pkg.sv
// Shared seven-segment constants: active-low digit patterns, anode enables, scan phases.
// Pure definitions; no state, no latency, no backpressure.
package ss_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] ANODE_OFF   = 8'hFF;
  localparam logic [7:0] ANODE_SLOT0 = 8'b11111110;
  localparam logic [7:0] ANODE_SLOT1 = 8'b11111101;
  localparam logic [7:0] ANODE_SLOT2 = 8'b11111011;
  localparam logic [7:0] ANODE_SLOT3 = 8'b11110111;

  typedef enum logic {PH_BLANK, PH_ON} phase_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] slot_anode(input logic [1:0] slot);
    case (slot)
      2'd0:    slot_anode = ANODE_SLOT0;
      2'd1:    slot_anode = ANODE_SLOT1;
      2'd2:    slot_anode = ANODE_SLOT2;
      default: slot_anode = ANODE_SLOT3;
    endcase
  endfunction

endpackage

// File: rtl/ss_pwm_gen.sv
// Free-running 8-bit PWM: pwm_on = (duty == 255) || (pwm_cnt < duty); duty sampled live.
// pwm_on is combinational from the registered counter; no backpressure.
module ss_pwm_gen (
  input  logic       CLK100MHZ,
  input  logic       RESET_N,
  input  logic [7:0] duty,
  output logic       pwm_on
);

  logic [7:0] pwm_cnt;

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) pwm_cnt <= 8'd0;
    else          pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = (duty == 8'hFF) || (pwm_cnt < duty);

endmodule

// File: rtl/ss_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking, PWM dimming and frame-aligned commit.
// Outputs registered, one cycle behind the slot state; load is always accepted (last write per frame wins).
module ss_scan_driver
  import ss_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 4
) (
  input  logic        CLK100MHZ,
  input  logic        RESET_N,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [7:0]  pwm_in,
  output logic [7:0]  SevenSegment,
  output logic [7:0]  SegmentDrivers,
  output logic        frame_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(SLOT_CYCLES - 2);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
  localparam logic [1:0]    LAST_SLOT = 2'(NUM_DIGITS - 1);
  localparam phase_t        RST_PHASE = (BLANK_CYCLES > 0) ? PH_BLANK : PH_ON;

  phase_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    slot;
  logic [15:0]   active_bcd;
  logic [3:0]    active_dp;
  logic [15:0]   pend_bcd;
  logic [3:0]    pend_dp;
  logic          pend_vld;
  logic          pwm_on;
  logic          slot_end;
  logic          frame_end;
  logic          pre_frame_end;
  logic [3:0]    digit;
  logic [6:0]    seg_pat;

  ss_pwm_gen u_pwm (
    .CLK100MHZ (CLK100MHZ),
    .RESET_N   (RESET_N),
    .duty      (pwm_in),
    .pwm_on    (pwm_on)
  );

  always_comb begin
    slot_end      = (cnt == LAST_CNT);
    frame_end     = slot_end && (slot == LAST_SLOT);
    pre_frame_end = (cnt == PRE_CNT) && (slot == LAST_SLOT);
    cnt_nxt       = slot_end ? '0 : cnt + 1'b1;
    digit         = active_bcd[{slot, 2'b00} +: 4];
    // Leading-zero suppression only ever applies to the hrs2 slot.
    if (blank_lz && (slot == LAST_SLOT) && (digit == 4'd0)) seg_pat = SEG_BLANK;
    else                                                    seg_pat = bcd_to_seg(digit);
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= RST_PHASE;
      cnt            <= '0;
      slot           <= 2'd0;
      active_bcd     <= 16'd0;
      active_dp      <= 4'd0;
      pend_bcd       <= 16'd0;
      pend_dp        <= 4'd0;
      pend_vld       <= 1'b0;
      SevenSegment   <= 8'hFF;
      SegmentDrivers <= ANODE_OFF;
      frame_done     <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      state      <= (cnt_nxt < BLANK_C) ? PH_BLANK : PH_ON;
      // Registered one cycle early so the pulse coincides with the commit cycle.
      frame_done <= pre_frame_end;
      if (slot_end) slot <= slot + 2'd1;

      case (state)
        PH_ON: begin
          SevenSegment   <= {~active_dp[slot], seg_pat};
          SegmentDrivers <= pwm_on ? slot_anode(slot) : ANODE_OFF;
        end
        default: begin
          SevenSegment   <= 8'hFF;
          SegmentDrivers <= ANODE_OFF;
        end
      endcase

      // A load landing on the frame boundary bypasses pending and wins over older pending data.
      if (frame_end) begin
        if (load) begin
          active_bcd <= bcd_in;
          active_dp  <= dp_in;
        end else if (pend_vld) begin
          active_bcd <= pend_bcd;
          active_dp  <= pend_dp;
        end
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ss_scan_driver.sv
// Scoreboard bench for ss_scan_driver with short slots: expected slot frames are queued, a monitor checks each anode turn-on.
module tb_ss_scan_driver;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic        CLK100MHZ = 1'b0;
  logic        RESET_N;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [7:0]  pwm_in;
  logic [7:0]  SevenSegment;
  logic [7:0]  SegmentDrivers;
  logic        frame_done;

  always #5 CLK100MHZ = ~CLK100MHZ;

  ss_scan_driver #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .NUM_DIGITS(4)) dut (
    .CLK100MHZ      (CLK100MHZ),
    .RESET_N        (RESET_N),
    .bcd_in         (bcd_in),
    .dp_in          (dp_in),
    .load           (load),
    .blank_lz       (blank_lz),
    .pwm_in         (pwm_in),
    .SevenSegment   (SevenSegment),
    .SegmentDrivers (SegmentDrivers),
    .frame_done     (frame_done)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];  // {anode, dp_n, seg[6:0]}
  logic [7:0]  mon_prev = 8'hFF;
  logic [15:0] mon_exp;
  // Active-high {g..a} patterns for digits 0-9.
  logic [6:0]  ah [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  int an_err, seg_err, fd_err, fd_cnt, c, k, n;
  logic [7:0] exp_an, exp_sg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wait_fd();
    int i = 0;
    do begin tick(); i++; end while (!frame_done && i < 100);
    if (!frame_done) begin
      tests++;
      fails++;
      $display("FAIL wait_fd: frame_done not seen within %0d cycles", i);
    end
  endtask

  task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic lz);
    for (int s = 0; s < 4; s++) begin
      logic [3:0] d;
      logic [6:0] g;
      logic [7:0] an;
      d = bcd[4*s +: 4];
      if (d > 4'd9 || (s == 3 && lz && d == 4'd0)) g = 7'h7F;
      else                                          g = ~ah[d];
      an = 8'hFF ^ (8'h01 << s);
      exp_q.push_back({an, ~dp[s], g});
    end
  endtask

  task automatic load_word(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic count_on(input int cycles, output int cnt_on);
    cnt_on = 0;
    repeat (cycles) begin
      tick();
      if (SegmentDrivers != 8'hFF) cnt_on++;
    end
  endtask

  // Monitor: each time an anode turns on, compare the presented digit with the next queued expectation.
  initial begin
    forever begin
      tick();
      if (RESET_N && SegmentDrivers != 8'hFF && mon_prev == 8'hFF && exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("sb_slot", 32'({SegmentDrivers, SevenSegment}), 32'(mon_exp));
      end
      mon_prev = SegmentDrivers;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; bcd_in = 16'h0; dp_in = 4'h0; load = 1'b0; blank_lz = 1'b0; pwm_in = 8'hFF;
    repeat (5) tick();
    check("rst_seg", 32'(SevenSegment), 32'hFF);
    check("rst_an", 32'(SegmentDrivers), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'h0);

    // Scan order/timing: after m edges the outputs reflect internal cycle m-1.
    @(negedge CLK100MHZ) RESET_N = 1'b1;
    an_err = 0; seg_err = 0; fd_err = 0; fd_cnt = 0;
    for (int m = 1; m <= 70; m++) begin
      tick();
      n = m - 1;
      exp_an = (n % SLOT < BLANK) ? 8'hFF : 8'hFF ^ (8'h01 << ((n / SLOT) % 4));
      exp_sg = (n % SLOT < BLANK) ? 8'hFF : 8'hC0;
      if (SegmentDrivers !== exp_an) an_err++;
      if (SevenSegment !== exp_sg) seg_err++;
      if (frame_done !== (m % 32 == 31)) fd_err++;
      if (frame_done) fd_cnt++;
    end
    check("scan_anode_errs", 32'(an_err), 32'd0);
    check("scan_seg_errs", 32'(seg_err), 32'd0);
    check("frame_done_pos_errs", 32'(fd_err), 32'd0);
    check("frame_done_count", 32'(fd_cnt), 32'd2);

    // Encoding sweep: loads on the frame_done cycle commit straight away.
    wait_fd();
    for (int v = 0; v <= 10; v++) begin
      load_word(16'(v), (v == 5) ? 4'b0001 : 4'b0000);
      push_frame(16'(v), (v == 5) ? 4'b0001 : 4'b0000, 1'b0);
      wait_fd();
    end

    // Deferred commit: a mid-slot-1 load must not appear until the next frame.
    push_frame(16'h000A, 4'b0000, 1'b0);
    repeat (12) tick();
    load_word(16'h1234, 4'b0000);
    wait_fd();
    push_frame(16'h1234, 4'b0000, 1'b0);
    repeat (12) tick();
    load_word(16'h5555, 4'b1111);
    wait_fd();
    blank_lz = 1'b1;
    load_word(16'h0930, 4'b1000);
    push_frame(16'h0930, 4'b1000, 1'b1);
    wait_fd();
    push_frame(16'h0930, 4'b1000, 1'b1);
    wait_fd();
    blank_lz = 1'b0;
    push_frame(16'h0930, 4'b1000, 1'b0);
    wait_fd();
    check("sb_drain_a", 32'(exp_q.size()), 32'd0);

    // Brightness: ON phase is 6/8 of cycles, so 256 cycles at duty 128 give 96 active.
    pwm_in = 8'd0;
    count_on(64, c);
    check("pwm0_active", 32'(c), 32'd0);
    pwm_in = 8'd128;
    tick();
    count_on(256, c);
    check("pwm128_active", 32'(c), 32'd96);
    pwm_in = 8'hFF;
    tick();
    count_on(256, c);
    check("pwm255_active", 32'(c), 32'd192);

    // Reset mid-ON with pending data outstanding.
    load_word(16'h7777, 4'b1111);
    k = 0;
    while (SegmentDrivers == 8'hFF && k < 50) begin tick(); k++; end
    check("pre_rst_active", 32'(SegmentDrivers != 8'hFF), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_async_an", 32'(SegmentDrivers), 32'hFF);
    check("rst_async_seg", 32'(SevenSegment), 32'hFF);
    check("rst_async_fd", 32'(frame_done), 32'h0);
    repeat (3) tick();
    @(negedge CLK100MHZ) RESET_N = 1'b1;
    push_frame(16'h0000, 4'b0000, 1'b0);
    tick();
    check("restart_blank0", 32'(SegmentDrivers), 32'hFF);
    tick();
    check("restart_blank1", 32'(SegmentDrivers), 32'hFF);
    tick();
    check("restart_slot0", 32'(SegmentDrivers), 32'hFE);
    wait_fd();
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_fd();
    check("sb_drain_b", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
